// File: rtl/pico_sample_feeder.sv
// Fetches 32-bit flash words and plays them as low/high 16-bit samples, one per sample_tick.
// Optional per-sample PicoBlaze handshake is enabled by macro PICO_HANDSHAKE_EN.
module pico_sample_feeder #(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_en,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [15:0]       audio_out,
  output logic              audio_valid,
  output logic [7:0]        pico_sample,
  output logic              start_pico,
  output logic              address_ready_for_pico,
  input  logic              pico_done,
  output logic              playing,
  output logic              done,
  output logic              overrun
);

`ifdef PICO_HANDSHAKE_EN
  localparam logic HS_EN = 1'b1;
`else
  localparam logic HS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, TICK_LO, TICK_HI, PICO_WAIT} state_t;

  state_t              state_q, state_d;
  logic                hi_q, hi_d;
  logic                abort_q, abort_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         word_q, word_d;
  logic                pending_q, pending_d;
  logic [15:0]         audio_q, audio_d;
  logic                valid_q, valid_d;
  logic [7:0]          pico_q, pico_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                consume, fire_done;
  logic [15:0]         half;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hi_q      <= 1'b0;
      abort_q   <= 1'b0;
      addr_q    <= '0;
      word_q    <= '0;
      pending_q <= 1'b0;
      audio_q   <= '0;
      valid_q   <= 1'b0;
      pico_q    <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      abort_q   <= abort_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      pending_q <= pending_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      pico_q    <= pico_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    abort_d   = abort_q;
    addr_d    = addr_q;
    word_d    = word_q;
    consume   = 1'b0;
    fire_done = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (play_en) begin
          addr_d  = addr_start;
          state_d = REQ;
        end
      end
      REQ: begin
        // A read already on the bus must be accepted before an abort can land.
        if (!play_en) abort_d = 1'b1;
        if (!flash_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (!play_en) abort_d = 1'b1;
        if (flash_readdatavalid) begin
          if (abort_q || !play_en) begin
            state_d = IDLE;
          end else begin
            word_d  = flash_readdata;
            hi_d    = 1'b0;
            state_d = TICK_LO;
          end
        end
      end
      TICK_LO, TICK_HI: begin
        if (!play_en) begin
          state_d = IDLE;
        end else if (pending_q || sample_tick) begin
          consume = 1'b1;
          hi_d    = (state_q == TICK_HI);
          if (HS_EN) begin
            state_d = PICO_WAIT;
          end else if (state_q == TICK_LO) begin
            state_d = TICK_HI;
          end else if (addr_q == addr_end) begin
            fire_done = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = REQ;
          end
        end
      end
      PICO_WAIT: begin
        if (!play_en) begin
          state_d = IDLE;
        end else if (pico_done) begin
          if (!hi_q) begin
            state_d = TICK_HI;
          end else if (addr_q == addr_end) begin
            fire_done = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign half = (state_q == TICK_HI) ? word_q[31:16] : word_q[15:0];

  always_comb begin
    audio_d   = consume ? half : audio_q;
    valid_d   = consume;
    pico_d    = (consume && HS_EN) ? half[15:8] : pico_q;
    done_d    = fire_done;
    ready_d   = ready_q;
    if (consume) begin
      ready_d = HS_EN;
    end else if (state_q == IDLE || (state_q == PICO_WAIT && (!play_en || pico_done))) begin
      ready_d = 1'b0;
    end
    // Ticks only count while a playback is active; stale idle ticks are dropped.
    if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (consume) begin
      pending_d = pending_q & sample_tick;
    end else begin
      pending_d = pending_q | sample_tick;
    end
    overrun_d = overrun_q;
    if (state_q == IDLE) begin
      if (play_en) overrun_d = 1'b0;
    end else if (sample_tick && pending_q && !consume) begin
      overrun_d = 1'b1;
    end
  end

  assign flash_read             = (state_q == REQ);
  assign flash_address          = addr_q;
  assign audio_out              = audio_q;
  assign audio_valid            = valid_q;
  assign pico_sample            = pico_q;
  assign start_pico             = HS_EN && (state_q != IDLE);
  assign address_ready_for_pico = ready_q;
  assign playing                = (state_q != IDLE);
  assign done                   = done_q;
  assign overrun                = overrun_q;

endmodule
